mole_controller: RTL and testbench



---
 rtl/whackamole_pkg.sv | 37 +++
 rtl/mole_controller_if.sv | 25 ++
 rtl/lfsr8.sv | 31 +++
 rtl/mole_controller.sv | 183 ++++++++++++++++++
 tb/tb_mole_controller.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/whackamole_pkg.sv
// Shared types and constants for the whack-a-mole game-play stage.
package whackamole_pkg;

  localparam int NUM_HOLES = 4;
  localparam int HOLE_W    = 2;

  // Feedback taps 8,6,5,4 (1-based) of the 8-bit Fibonacci LFSR, as a bit mask.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Take the low LFSR bits as a hole; never repeat the previous hole back to back.
  function automatic logic [HOLE_W-1:0] pick_hole(input logic [HOLE_W-1:0] rnd,
                                                  input logic [HOLE_W-1:0] last);
    logic [HOLE_W-1:0] h;
    h = rnd;
    if (h == last) begin
      h = h + 2'd1;
    end else begin
      h = rnd;
    end
    return h;
  endfunction

  // One-hot lamp pattern for a hole index.
  function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [HOLE_W-1:0] h);
    logic [NUM_HOLES-1:0] one;
    one = {{(NUM_HOLES-1){1'b0}}, 1'b1};
    return one << h;
  endfunction

endpackage

// File: rtl/mole_controller_if.sv
// Game-play bus: control inputs from the system and lamp/score outputs.
interface mole_controller_if #(
  parameter int SCORE_W = 8
);
  import whackamole_pkg::*;

  logic                 restart_game;
  logic                 game_over;
  logic [NUM_HOLES-1:0] whack;
  logic [NUM_HOLES-1:0] mole_on;
  logic [SCORE_W-1:0]   score;
  logic                 hit_pulse;
  logic                 miss_pulse;

  modport master (
    output restart_game, game_over, whack,
    input  mole_on, score, hit_pulse, miss_pulse
  );

  modport slave (
    input  restart_game, game_over, whack,
    output mole_on, score, hit_pulse, miss_pulse
  );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the hole-pick random source.
module lfsr8
  import whackamole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Shift left; XOR of the tapped bits enters at the LSB.
  always_comb begin
    q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
  end

  // Shift register; only the async reset reloads the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mole_controller.sv
// Whack-a-mole play controller: spawns moles, times them, scores whacks,
// and freezes when the upstream countdown reports game over.
module mole_controller
  import whackamole_pkg::*;
#(
  parameter int         TICK_DIV   = 500000,
  parameter int         GAP_TICKS  = 40,
  parameter int         LIFE_TICKS = 80,
  parameter int         SCORE_W    = 8,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  mole_controller_if.slave bus
);

  localparam int PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_TICKS = (GAP_TICKS > LIFE_TICKS) ? GAP_TICKS : LIFE_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [PRESC_W-1:0]   PRESC_MAX  = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0]   PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [CNT_W-1:0]     GAP_END    = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0]     LIFE_END   = CNT_W'(LIFE_TICKS);
  localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [SCORE_W-1:0]   SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0]   SCORE_ZERO = {SCORE_W{1'b0}};
  localparam logic [NUM_HOLES-1:0] NO_MOLE    = {NUM_HOLES{1'b0}};

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [HOLE_W-1:0]    last_hole_q, last_hole_d;
  logic                 restart_dly_q;

  logic                 tick_s;
  logic [CNT_W-1:0]     cnt_inc_s;
  logic [7:0]           lfsr_s;
  logic [HOLE_W-1:0]    hole_s;
  logic                 game_over_live_s;
  logic                 unused_lfsr_s;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_s)
  );

  // Upper LFSR bits only feed the shift register itself.
  assign unused_lfsr_s = ^lfsr_s[7:HOLE_W];

  assign tick_s    = (presc_q == PRESC_MAX);
  assign cnt_inc_s = cnt_q + CNT_W'(1);
  assign hole_s    = pick_hole(lfsr_s[HOLE_W-1:0], last_hole_q);

  // The countdown drops game_over one cycle after restart, so its stale level is masked then.
  assign game_over_live_s = bus.game_over & ~restart_dly_q;

  // Prescaler: wraps at TICK_DIV-1 and re-phases with every new game.
  always_comb begin
    presc_d = presc_q;
    if (bus.restart_game) begin
      presc_d = PRESC_ZERO;
    end else if (tick_s) begin
      presc_d = PRESC_ZERO;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Game FSM next state: restart beats game_over, which beats normal play.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mole_d      = mole_q;
    score_d     = score_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    last_hole_d = last_hole_q;
    if (bus.restart_game) begin
      state_d = GAP;
      cnt_d   = CNT_ZERO;
      mole_d  = NO_MOLE;
      score_d = SCORE_ZERO;
    end else if (game_over_live_s && ((state_q == GAP) || (state_q == UP))) begin
      state_d = DONE;
      mole_d  = NO_MOLE;
    end else begin
      case (state_q)
        IDLE: begin
          mole_d = NO_MOLE;
        end
        GAP: begin
          mole_d = NO_MOLE;
          miss_d = |bus.whack;
          if (tick_s) begin
            if (cnt_inc_s == GAP_END) begin
              state_d     = UP;
              cnt_d       = CNT_ZERO;
              mole_d      = hole_onehot(hole_s);
              last_hole_d = hole_s;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        UP: begin
          // A correct whack wins even when the lifetime expires on the same cycle.
          if (|(bus.whack & mole_q)) begin
            state_d = GAP;
            cnt_d   = CNT_ZERO;
            mole_d  = NO_MOLE;
            hit_d   = 1'b1;
            if (score_q == SCORE_MAX) begin
              score_d = score_q;
            end else begin
              score_d = score_q + SCORE_W'(1);
            end
          end else begin
            miss_d = |bus.whack;
            if (tick_s) begin
              if (cnt_inc_s == LIFE_END) begin
                state_d = GAP;
                cnt_d   = CNT_ZERO;
                mole_d  = NO_MOLE;
              end else begin
                cnt_d = cnt_inc_s;
              end
            end else begin
              cnt_d = cnt_q;
            end
          end
        end
        DONE: begin
          mole_d = NO_MOLE;
        end
        default: begin
          state_d = IDLE;
          mole_d  = NO_MOLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      presc_q       <= PRESC_ZERO;
      cnt_q         <= CNT_ZERO;
      mole_q        <= NO_MOLE;
      score_q       <= SCORE_ZERO;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      last_hole_q   <= {HOLE_W{1'b0}};
      restart_dly_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      mole_q        <= mole_d;
      score_q       <= score_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      last_hole_q   <= last_hole_d;
      restart_dly_q <= bus.restart_game;
    end
  end

  assign bus.mole_on    = mole_q;
  assign bus.score      = score_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;

endmodule

// File: tb/tb_mole_controller.sv
// Directed bench for mole_controller with TICK_DIV=4, GAP_TICKS=2, LIFE_TICKS=3.
module tb_mole_controller;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_lfsr;
  logic [1:0] m_last = 2'd0;
  int         cyc;
  int         exp_score;
  logic [1:0] h;
  logic [1:0] wrong_h;

  mole_controller_if #(.SCORE_W(8)) bus ();

  mole_controller #(
    .TICK_DIV   (4),
    .GAP_TICKS  (2),
    .LIFE_TICKS (3),
    .SCORE_W    (8),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4 Fibonacci, shift left, feedback into bit 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [1:0] exp_pick(input logic [7:0] l, input logic [1:0] last);
    logic [1:0] v;
    v = l[1:0];
    if (v == last) v = v + 2'd1;
    return v;
  endfunction

  function automatic logic [3:0] exp_onehot(input logic [1:0] v);
    logic [3:0] r;
    r = 4'b0000;
    r[v] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step edges until a mole lights, checking it lands where the reference says.
  task automatic wait_spawn(input int max_cyc, output int n, output logic [1:0] hole);
    logic [1:0] cand;
    bit         found;
    found = 1'b0;
    n     = 0;
    hole  = 2'd0;
    while (!found && n < max_cyc) begin
      cand = exp_pick(m_lfsr, m_last);
      @(negedge clk);
      n++;
      if (bus.mole_on != 4'b0000) begin
        found = 1'b1;
        hole  = cand;
      end
    end
    chk("spawn_seen", {31'd0, found}, 32'd1);
    if (found) begin
      chk("spawn_hole", {28'd0, bus.mole_on}, {28'd0, exp_onehot(cand)});
      m_last = cand;
    end
  endtask

  initial begin
    bus.restart_game = 1'b0;
    bus.game_over    = 1'b0;
    bus.whack        = 4'b0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mole", {28'd0, bus.mole_on}, 32'd0);
    chk("rst_score", {24'd0, bus.score}, 32'd0);
    chk("rst_pulses", {30'd0, bus.hit_pulse, bus.miss_pulse}, 32'd0);
    rst_n = 1'b1;

    // 1: idle ignores whacks for 50 cycles
    for (int i = 0; i < 50; i++) begin
      bus.whack = 4'(i);
      @(negedge clk);
      chk("idle_quiet", {18'd0, bus.mole_on, bus.score, bus.hit_pulse, bus.miss_pulse}, 32'd0);
    end
    bus.whack = 4'b0000;

    // 2: restart, first mole 8 cycles later, hit 2 cycles after rising
    bus.restart_game = 1'b1;
    @(negedge clk);
    bus.restart_game = 1'b0;
    chk("restart_score", {24'd0, bus.score}, 32'd0);
    wait_spawn(20, cyc, h);
    chk("spawn_latency", cyc, 32'd8);
    @(negedge clk);
    bus.whack = exp_onehot(h);
    @(negedge clk);
    bus.whack = 4'b0000;
    chk("hit_pulse", {31'd0, bus.hit_pulse}, 32'd1);
    chk("hit_score", {24'd0, bus.score}, 32'd1);
    chk("hit_mole_off", {28'd0, bus.mole_on}, 32'd0);
    chk("hit_no_miss", {31'd0, bus.miss_pulse}, 32'd0);
    @(negedge clk);
    chk("hit_one_cycle", {31'd0, bus.hit_pulse}, 32'd0);
    wait_spawn(20, cyc, h);
    chk("respawn_latency", cyc + 3, 32'd8);

    // 3: unwhacked mole drops after 12 cycles, silently
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      chk("life_quiet", {30'd0, bus.hit_pulse, bus.miss_pulse}, 32'd0);
    end while (bus.mole_on != 4'b0000 && cyc < 20);
    chk("life_len", cyc, 32'd12);
    chk("life_score", {24'd0, bus.score}, 32'd1);

    // 4: wrong hole is a miss, then wrong+right is a hit, then gap whack is a miss
    wait_spawn(20, cyc, h);
    chk("gap_len", cyc, 32'd8);
    wrong_h   = h + 2'd1;
    bus.whack = exp_onehot(wrong_h);
    @(negedge clk);
    chk("wrong_miss", {31'd0, bus.miss_pulse}, 32'd1);
    chk("wrong_no_hit", {31'd0, bus.hit_pulse}, 32'd0);
    chk("wrong_mole_stays", {28'd0, bus.mole_on}, {28'd0, exp_onehot(h)});
    bus.whack = exp_onehot(wrong_h) | exp_onehot(h);
    @(negedge clk);
    chk("multi_hit", {31'd0, bus.hit_pulse}, 32'd1);
    chk("multi_no_miss", {31'd0, bus.miss_pulse}, 32'd0);
    chk("multi_score", {24'd0, bus.score}, 32'd2);
    chk("multi_mole_off", {28'd0, bus.mole_on}, 32'd0);
    bus.whack = 4'b1000;
    @(negedge clk);
    bus.whack = 4'b0000;
    chk("gap_miss", {31'd0, bus.miss_pulse}, 32'd1);
    chk("gap_no_hit", {31'd0, bus.hit_pulse}, 32'd0);

    // 5: game_over while up discards the pending whack and freezes play
    wait_spawn(20, cyc, h);
    bus.game_over = 1'b1;
    bus.whack     = exp_onehot(h);
    @(negedge clk);
    chk("go_mole_off", {28'd0, bus.mole_on}, 32'd0);
    chk("go_pulses", {30'd0, bus.hit_pulse, bus.miss_pulse}, 32'd0);
    chk("go_score", {24'd0, bus.score}, 32'd2);
    bus.whack = 4'b1111;
    repeat (20) begin
      @(negedge clk);
      chk("done_quiet", {26'd0, bus.mole_on, bus.hit_pulse, bus.miss_pulse}, 32'd0);
      chk("done_score", {24'd0, bus.score}, 32'd2);
    end
    bus.whack        = 4'b0000;
    bus.restart_game = 1'b1;
    @(negedge clk);
    bus.restart_game = 1'b0;
    chk("rst2_score", {24'd0, bus.score}, 32'd0);
    chk("rst2_mole", {28'd0, bus.mole_on}, 32'd0);
    @(negedge clk);
    bus.game_over = 1'b0;
    wait_spawn(20, cyc, h);
    chk("rst2_latency", cyc + 1, 32'd8);

    // 6a: correct whack on the expiry cycle counts as a hit
    repeat (11) @(negedge clk);
    bus.whack = exp_onehot(h);
    @(negedge clk);
    bus.whack = 4'b0000;
    chk("exp_hit_pulse", {31'd0, bus.hit_pulse}, 32'd1);
    chk("exp_hit_score", {24'd0, bus.score}, 32'd1);
    chk("exp_hit_mole_off", {28'd0, bus.mole_on}, 32'd0);
    chk("exp_hit_no_miss", {31'd0, bus.miss_pulse}, 32'd0);

    // 6b: climb to 255, then one more hit saturates but still pulses
    exp_score = 1;
    while (exp_score < 255) begin
      wait_spawn(20, cyc, h);
      bus.whack = exp_onehot(h);
      @(negedge clk);
      bus.whack = 4'b0000;
      exp_score++;
      chk("sat_climb", {24'd0, bus.score}, exp_score);
    end
    wait_spawn(20, cyc, h);
    bus.whack = exp_onehot(h);
    @(negedge clk);
    bus.whack = 4'b0000;
    chk("sat_hold", {24'd0, bus.score}, 32'd255);
    chk("sat_hit", {31'd0, bus.hit_pulse}, 32'd1);

    // Asynchronous reset mid-game clears everything at once
    wait_spawn(20, cyc, h);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mole", {28'd0, bus.mole_on}, 32'd0);
    chk("async_score", {24'd0, bus.score}, 32'd0);
    chk("async_pulses", {30'd0, bus.hit_pulse, bus.miss_pulse}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 2'd0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
